// File: rtl/async_event_sync_pkg.sv
// -----------------------------------------------------------------------------
// async_event_pkg
// Shared definitions for the multi-channel asynchronous event synchroniser:
//   - edge_mode_t     : per-channel edge selection encoding (2 bits)
//   - MIN_SYNC_STAGES : smallest synchroniser depth that is considered safe
//   - select_edge()   : maps a mode and the rise/fall detections to an event
// -----------------------------------------------------------------------------
package async_event_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int MIN_SYNC_STAGES = 2;

  // Event selection for one channel. Bit 0 of the mode enables rising edges
  // and bit 1 enables falling edges, so EDGE_BOTH reports either.
  function automatic logic select_edge(input edge_mode_t m,
                                       input logic       rise,
                                       input logic       fall);
    logic ev;
    ev = 1'b0;
    case (m)
      EDGE_RISE: ev = rise;
      EDGE_FALL: ev = fall;
      EDGE_BOTH: ev = rise | fall;
      default:   ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage : async_event_pkg

// File: rtl/async_event_sync_chan.sv
// -----------------------------------------------------------------------------
// event_sync_chan
// One channel of the asynchronous event synchroniser: a SYNC_STAGES-deep
// synchroniser chain, a history flop for edge detection, mode-selected edge
// event, a registered 1-cycle pulse, a saturating event counter and the
// sticky / overflow flags.
//
// Ports
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   async_i        in   asynchronous input (any time)
//   mode_i         in   edge mode: 00 off, 01 rise, 10 fall, 11 both
//   clr_i          in   synchronous clear of count / sticky / overflow
//   warmup_mask_i  in   high while the shared warm-up counter is running
//   level_o        out  synchronised level (last chain stage)
//   pulse_o        out  1-cycle event pulse
//   sticky_o       out  set on event, held until clr_i
//   overflow_o     out  set on an event while the count is saturated
//   count_o        out  saturating event count
// -----------------------------------------------------------------------------
module event_sync_chan
  import async_event_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  input  logic             warmup_mask_i,
  output logic             level_o,
  output logic             pulse_o,
  output logic             sticky_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment: the counter holds at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) r = v;
    else              r = v + CNT_W'(1);
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic level;
  logic rise;
  logic fall;
  logic ev;

  // ---- synchroniser chain: bit 0 is the metastability capture flop ----
  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  assign level  = sync_q[SYNC_STAGES-1];

  // ---- edge detect against the history flop ----
  // hist_q follows level every cycle regardless of mode, so switching the
  // mode never manufactures an edge.
  assign rise    = level & ~hist_q;
  assign fall    = ~level & hist_q;
  assign ev      = select_edge(edge_mode_t'(mode_i), rise, fall);
  assign pulse_d = ev & ~warmup_mask_i;

  // ---- counter / flags, updated on the same edge that raises the pulse ----
  // A clear in the same cycle as an event is applied first, so the event is
  // counted into a freshly cleared channel (count=1, overflow=0).
  always_comb begin
    count_d  = count_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      count_d  = '0;
      sticky_d = 1'b0;
      ovf_d    = 1'b0;
    end
    if (pulse_d) begin
      sticky_d = 1'b1;
      if (clr_i) begin
        count_d = CNT_W'(1);
      end else begin
        if (count_q == CNT_MAX) ovf_d = 1'b1;
        count_d = sat_inc(count_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= level;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
    end
  end

  assign level_o    = level;
  assign pulse_o    = pulse_q;
  assign sticky_o   = sticky_q;
  assign overflow_o = ovf_q;
  assign count_o    = count_q;

endmodule : event_sync_chan

// File: rtl/async_event_sync.sv
// -----------------------------------------------------------------------------
// async_event_sync
// Multi-channel asynchronous event synchroniser. Each channel brings an
// asynchronous level/toggle input into the clk domain, detects edges selected
// by a runtime mode and produces a 1-cycle pulse, a sticky flag, an overflow
// flag and a saturating event counter. A shared warm-up counter masks edge
// detection right after reset so inputs already high at release produce no
// event.
//
// Ports
//   clk        in   clock; all outputs registered on posedge clk
//   rst        in   asynchronous active-low reset
//   async_in   in   CHANNELS asynchronous inputs
//   mode       in   2*CHANNELS; channel i uses mode[2i+1:2i]
//   clr        in   CHANNELS synchronous clears of count/sticky/overflow
//   level_out  out  CHANNELS synchronised levels
//   pulse_out  out  CHANNELS 1-cycle event pulses
//   sticky     out  CHANNELS sticky event flags
//   overflow   out  CHANNELS overflow flags
//   count      out  CHANNELS*CNT_W; count[i*CNT_W +: CNT_W] is channel i
// -----------------------------------------------------------------------------
module async_event_sync
  import async_event_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       async_in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       sticky,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS*CNT_W-1:0] count
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("async_event_sync: SYNC_STAGES must be at least 2");
  end
  if (CHANNELS < 1) begin : g_bad_chan
    $error("async_event_sync: CHANNELS must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("async_event_sync: CNT_W must be at least 1");
  end

  // Warm-up length SYNC_STAGES+1 covers the chain fill plus the history
  // flop, i.e. the first cycle in which a level present at reset release
  // could look like an edge.
  localparam int              WU_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0] WU_LOAD = WU_W'(SYNC_STAGES + 1);

  logic [WU_W-1:0] warmup_q, warmup_d;
  logic            warmup_mask;

  // ---- warm-up counter: counts down once per cycle after reset release ----
  assign warmup_mask = (warmup_q != '0);
  assign warmup_d    = warmup_mask ? (warmup_q - WU_W'(1)) : warmup_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) warmup_q <= WU_LOAD;
    else      warmup_q <= warmup_d;
  end

  // ---- per-channel datapath ----
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    event_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst),
      .async_i       (async_in[i]),
      .mode_i        (mode[2*i +: 2]),
      .clr_i         (clr[i]),
      .warmup_mask_i (warmup_mask),
      .level_o       (level_out[i]),
      .pulse_o       (pulse_out[i]),
      .sticky_o      (sticky[i]),
      .overflow_o    (overflow[i]),
      .count_o       (count[i*CNT_W +: CNT_W])
    );
  end

endmodule : async_event_sync

// File: tb/tb_async_event_sync.sv
module tb_async_event_sync;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int LAT  = SYNC + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    async_in;
  logic [2*NCH-1:0]  mode;
  logic [NCH-1:0]    clr;
  logic [NCH-1:0]    level_out;
  logic [NCH-1:0]    pulse_out;
  logic [NCH-1:0]    sticky;
  logic [NCH-1:0]    overflow;
  logic [NCH*CW-1:0] count;

  async_event_sync #(
    .CHANNELS    (NCH),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .mode      (mode),
    .clr       (clr),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .sticky    (sticky),
    .overflow  (overflow),
    .count     (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            due;
    logic [CW-1:0] cnt;
    logic          stk;
    logic          ovf;
  } exp_t;

  exp_t          exp_q [NCH][$];
  logic [CW-1:0] m_cnt [NCH];
  logic          m_stk [NCH];
  logic          m_ovf [NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return count[ch*CW +: CW];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      m_cnt[c] = '0;
      m_stk[c] = 1'b0;
      m_ovf[c] = 1'b0;
    end
  endtask

  // Drive a new level on a channel; if the current mode selects the resulting
  // transition, predict the pulse time and the post-event counter/flags.
  task automatic drive(input int ch, input logic v, input logic with_clr);
    logic       old;
    logic [1:0] md;
    logic       ev;
    exp_t       e;
    old          = async_in[ch];
    async_in[ch] = v;
    md           = mode[2*ch +: 2];
    ev           = (v & ~old & md[0]) | (~v & old & md[1]);
    if (ev) begin
      if (with_clr) begin
        m_cnt[ch] = '0;
        m_stk[ch] = 1'b0;
        m_ovf[ch] = 1'b0;
      end
      if (m_cnt[ch] == {CW{1'b1}}) m_ovf[ch] = 1'b1;
      else                         m_cnt[ch] = m_cnt[ch] + 1'b1;
      m_stk[ch] = 1'b1;
      e.due = cyc + LAT;
      e.cnt = m_cnt[ch];
      e.stk = m_stk[ch];
      e.ovf = m_ovf[ch];
      exp_q[ch].push_back(e);
    end
  endtask

  // Rising event on ch with clr[ch] held exactly on the edge that raises the pulse.
  task automatic event_with_clr(input int ch);
    drive(ch, 1'b1, 1'b1);
    tick(LAT - 1);
    clr[ch] = 1'b1;
    tick(1);
    clr[ch] = 1'b0;
    check($sformatf("clr_ev_cnt%0d", ch), 32'(cnt_of(ch)), 32'd1);
    check($sformatf("clr_ev_stk%0d", ch), 32'(sticky[ch]), 32'd1);
    check($sformatf("clr_ev_ovf%0d", ch), 32'(overflow[ch]), 32'd0);
    tick(3);
  endtask

  task automatic clear_chan(input int ch);
    clr[ch] = 1'b1;
    tick(1);
    clr[ch] = 1'b0;
    m_cnt[ch] = '0;
    m_stk[ch] = 1'b0;
    m_ovf[ch] = 1'b0;
    check($sformatf("clr_cnt%0d", ch), 32'(cnt_of(ch)), 32'd0);
    check($sformatf("clr_stk%0d", ch), 32'(sticky[ch]), 32'd0);
    check($sformatf("clr_ovf%0d", ch), 32'(overflow[ch]), 32'd0);
  endtask

  // Scoreboard: every cycle each channel's pulse is compared with the queue
  // head; a due entry is consumed and its counter/flags compared.
  exp_t mon_e;
  logic mon_exp_p;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int c = 0; c < NCH; c++) begin
        mon_exp_p = (exp_q[c].size() != 0) && (exp_q[c][0].due == cyc);
        check($sformatf("pulse%0d@%0d", c, cyc), 32'(pulse_out[c]), 32'(mon_exp_p));
        if (exp_q[c].size() != 0 && exp_q[c][0].due <= cyc) begin
          mon_e = exp_q[c].pop_front();
          if (mon_exp_p) begin
            check($sformatf("ev_cnt%0d@%0d", c, cyc), 32'(cnt_of(c)), 32'(mon_e.cnt));
            check($sformatf("ev_stk%0d@%0d", c, cyc), 32'(sticky[c]), 32'(mon_e.stk));
            check($sformatf("ev_ovf%0d@%0d", c, cyc), 32'(overflow[c]), 32'(mon_e.ovf));
          end
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    async_in = '0;
    clr      = '0;
    // ch0 rise, ch1 both, ch2 rise, ch3 rise
    mode     = {2'b01, 2'b01, 2'b11, 2'b01};
    model_reset();

    // ---- reset state, with async_in[0] already high ----
    async_in[0] = 1'b1;
    tick(3);
    check("rst_pulse",  32'(pulse_out), 32'd0);
    check("rst_sticky", 32'(sticky),    32'd0);
    check("rst_ovf",    32'(overflow),  32'd0);
    check("rst_count",  32'(count),     32'd0);
    check("rst_level",  32'(level_out), 32'd0);

    // ---- 1: input high through release -> no event ----
    #2 rst = 1'b1;
    tick(10);
    check("t1_cnt0",   32'(cnt_of(0)),   32'd0);
    check("t1_stk0",   32'(sticky[0]),   32'd0);
    check("t1_level0", 32'(level_out[0]), 32'd1);

    // ---- 2: single rising edge on ch0 ----
    drive(0, 1'b0, 1'b0);
    tick(5);
    drive(0, 1'b1, 1'b0);
    tick(6);
    check("t2_cnt0",   32'(cnt_of(0)),    32'd1);
    check("t2_stk0",   32'(sticky[0]),    32'd1);
    check("t2_level0", 32'(level_out[0]), 32'd1);

    // ---- 3: ch1 both edges, then falling only ----
    for (int k = 0; k < 5; k++) begin
      drive(1, ~async_in[1], 1'b0);
      tick(4);
    end
    tick(3);
    check("t3_cnt1_both", 32'(cnt_of(1)), 32'd5);
    mode[3:2] = 2'b10;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      drive(1, ~async_in[1], 1'b0);
      tick(4);
    end
    tick(3);
    check("t3_cnt1_fall", 32'(cnt_of(1)), 32'd8);

    // ---- 4: saturation and overflow on ch3 ----
    for (int k = 0; k < 17; k++) begin
      drive(3, 1'b1, 1'b0);
      tick(3);
      drive(3, 1'b0, 1'b0);
      tick(3);
    end
    tick(3);
    check("t4_cnt3", 32'(cnt_of(3)),   32'd15);
    check("t4_ovf3", 32'(overflow[3]), 32'd1);

    // ---- 5: clear together with an event, and clear alone ----
    drive(2, 1'b1, 1'b0);
    tick(4);
    drive(2, 1'b0, 1'b0);
    tick(4);
    event_with_clr(2);
    event_with_clr(3);
    clear_chan(0);

    // ---- 6: reset with events in flight ----
    drive(2, 1'b0, 1'b0);
    tick(4);
    mode[3:2] = 2'b11;
    tick(1);
    drive(2, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    tick(1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t6_pulse",  32'(pulse_out), 32'd0);
    check("t6_sticky", 32'(sticky),    32'd0);
    check("t6_ovf",    32'(overflow),  32'd0);
    check("t6_count",  32'(count),     32'd0);
    check("t6_level",  32'(level_out), 32'd0);
    tick(2);
    #2 rst = 1'b1;
    tick(8);
    check("t6_cnt1_warm", 32'(cnt_of(1)), 32'd0);
    check("t6_cnt2_warm", 32'(cnt_of(2)), 32'd0);
    check("t6_stk_warm",  32'(sticky),    32'd0);
    drive(2, 1'b0, 1'b0);
    tick(4);
    drive(2, 1'b1, 1'b0);
    tick(6);
    check("t6_cnt2_after", 32'(cnt_of(2)), 32'd1);

    // ---- drain ----
    tick(4);
    for (int c = 0; c < NCH; c++)
      check($sformatf("drain%0d", c), 32'(exp_q[c].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_async_event_sync
